// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types for the slave router: transfer kinds, response codes and router FSM states.
// No logic of its own; imported by the decoder and the router top.
package ahb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY   = 2'd1,
      NONSEQ = 2'd2,
      SEQ    = 2'd3
   } htrans_e;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      NODP = 2'd0,
      SLV  = 2'd1,
      ERR1 = 2'd2,
      ERR2 = 2'd3
   } router_state_e;

   // Owner index width, clamped to one bit so a single-slave build still has a register.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ahb_addr_decoder.sv
// Combinational priority address decoder: zero latency, no backpressure.
// Lowest matching slot wins on overlapping regions; sel is onehot on a hit and all-zero on a miss.
module ahb_addr_decoder
   import ahb_pkg::*;
#(
   parameter int                              ADDR_WIDTH = 32,
   parameter int                              N_SLAVES   = 4,
   parameter int                              IDX_W      = 2,
   parameter logic [N_SLAVES*ADDR_WIDTH-1:0]  SLAVE_BASE = '0,
   parameter logic [N_SLAVES*ADDR_WIDTH-1:0]  SLAVE_MASK = '0
) (
   input  logic [ADDR_WIDTH-1:0] addr_i,
   output logic [N_SLAVES-1:0]   sel_o,
   output logic                  hit_o,
   output logic [IDX_W-1:0]      idx_o
);

   always_comb begin
      hit_o = 1'b0;
      idx_o = '0;
      sel_o = '0;
      // Scan from the top so the lowest matching index is the last one written.
      for (int i = N_SLAVES - 1; i >= 0; i--) begin
         if ((addr_i & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
            hit_o = 1'b1;
            idx_o = IDX_W'(i);
         end
      end
      for (int i = 0; i < N_SLAVES; i++) begin
         sel_o[i] = hit_o && (int'(idx_o) == i);
      end
   end

endmodule

// File: rtl/ahb_slave_router.sv
// AHB-Lite decoder + response mux for N slaves with a built-in two-cycle ERROR default slave; zero-cycle decode,
// response follows the data-phase owner's HREADYOUT. Optional wait-state timeout under AHB_ROUTER_TIMEOUT_EN.
module ahb_slave_router
   import ahb_pkg::*;
#(
   parameter int                              ADDR_WIDTH     = 32,
   parameter int                              DATA_WIDTH     = 32,
   parameter int                              N_SLAVES       = 4,
   parameter logic [N_SLAVES*ADDR_WIDTH-1:0]  SLAVE_BASE     = '0,
   parameter logic [N_SLAVES*ADDR_WIDTH-1:0]  SLAVE_MASK     = '0,
   parameter int                              TIMEOUT_CYCLES = 256
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [ADDR_WIDTH-1:0]          m_addr,
   input  logic [1:0]                     m_trans,
   output logic [DATA_WIDTH-1:0]          m_rdata,
   output logic                           m_ready,
   output logic                           m_resp,
   output logic [N_SLAVES-1:0]            s_sel,
   input  logic [N_SLAVES*DATA_WIDTH-1:0] s_rdata,
   input  logic [N_SLAVES-1:0]            s_ready,
   input  logic [N_SLAVES-1:0]            s_resp,
   output logic                           timeout
);

   localparam int OW = idx_width(N_SLAVES);

   if (N_SLAVES < 1 || N_SLAVES > 16) begin : g_bad_n
      $error("ahb_slave_router: N_SLAVES must be 1..16");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_to
      $error("ahb_slave_router: TIMEOUT_CYCLES must be at least 1");
   end

   router_state_e   state_q;
   router_state_e   ap_state_d;
   logic [OW-1:0]   owner_q;
   logic [OW-1:0]   ap_owner_d;
   logic            dec_hit;
   logic [OW-1:0]   dec_idx;
   logic            addr_acc;
   htrans_e         trans;

   ahb_addr_decoder #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .N_SLAVES   (N_SLAVES),
      .IDX_W      (OW),
      .SLAVE_BASE (SLAVE_BASE),
      .SLAVE_MASK (SLAVE_MASK)
   ) u_dec (
      .addr_i (m_addr),
      .sel_o  (s_sel),
      .hit_o  (dec_hit),
      .idx_o  (dec_idx)
   );

   always_comb begin
      m_ready = 1'b1;
      m_resp  = HRESP_OKAY;
      m_rdata = '0;
      case (state_q)
         SLV: begin
            m_rdata = s_rdata[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
            m_ready = s_ready[owner_q];
            m_resp  = s_resp[owner_q];
         end
         ERR1: begin
            m_ready = 1'b0;
            m_resp  = HRESP_ERROR;
         end
         ERR2: begin
            m_resp  = HRESP_ERROR;
         end
         default: ;
      endcase
   end

   // Next data phase implied by the address phase currently on the bus.
   always_comb begin
      trans      = htrans_e'(m_trans);
      addr_acc   = m_ready && (trans == NONSEQ || trans == SEQ);
      ap_state_d = NODP;
      ap_owner_d = owner_q;
      if (addr_acc) begin
         if (dec_hit) begin
            ap_state_d = SLV;
            ap_owner_d = dec_idx;
         end else begin
            ap_state_d = ERR1;
         end
      end
   end

`ifdef AHB_ROUTER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] wait_cnt_q;
   logic          timeout_q;
   logic          wait_expired;

   assign wait_expired = (state_q == SLV) && !m_ready && (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));
   assign timeout      = timeout_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else if (state_q == SLV && !m_ready) begin
         if (wait_expired) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b1;
         end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
         end
      end else begin
         wait_cnt_q <= '0;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= NODP;
         owner_q <= '0;
      end else if (m_ready) begin
         state_q <= ap_state_d;
         owner_q <= ap_owner_d;
      end else if (state_q == ERR1) begin
         state_q <= ERR2;
`ifdef AHB_ROUTER_TIMEOUT_EN
      end else if (wait_expired) begin
         // The stalled owner is abandoned; its eventual HREADYOUT is never looked at.
         state_q <= ERR1;
`endif
      end
   end

endmodule

// File: tb/tb_ahb_slave_router.sv
// Scoreboard bench for ahb_slave_router: per-cycle expected bus outputs are queued as stimulus is driven
// and compared on the falling edge. The timeout scenario runs only when AHB_ROUTER_TIMEOUT_EN is defined.
module tb_ahb_slave_router;
   import ahb_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int N  = 4;
   localparam logic [N*AW-1:0] BASE     = {32'h3000, 32'h2000, 32'h1000, 32'h0000};
   localparam logic [N*AW-1:0] MASK     = {4{32'h0000_F000}};
   localparam logic [N*AW-1:0] OVL_BASE = {32'h3000, 32'h0000, 32'h1000, 32'h0000};
   localparam logic [1:0] T_ID = 2'd0, T_BS = 2'd1, T_NS = 2'd2, T_SQ = 2'd3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] m_addr = '0;
   logic [1:0]    m_trans = T_ID;
   logic [DW-1:0] m_rdata;
   logic          m_ready, m_resp, timeout;
   logic [N-1:0]  s_sel;
   logic [N*DW-1:0] s_rdata = {32'h0000_D3D3, 32'h0000_B2B2, 32'h0000_CAFE, 32'h0000_A0A0};
   logic [N-1:0]  s_ready = 4'hF;
   logic [N-1:0]  s_resp = 4'h0;

   logic [DW-1:0] ovl_rdata;
   logic          ovl_ready, ovl_resp, ovl_tmo;
   logic [N-1:0]  ovl_sel;

   always #5 clk = ~clk;

   ahb_slave_router #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_SLAVES(N),
      .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .rst(rst), .m_addr(m_addr), .m_trans(m_trans),
      .m_rdata(m_rdata), .m_ready(m_ready), .m_resp(m_resp), .s_sel(s_sel),
      .s_rdata(s_rdata), .s_ready(s_ready), .s_resp(s_resp), .timeout(timeout)
   );

   ahb_slave_router #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_SLAVES(N),
      .SLAVE_BASE(OVL_BASE), .SLAVE_MASK(MASK), .TIMEOUT_CYCLES(8)
   ) dut_ovl (
      .clk(clk), .rst(rst), .m_addr(m_addr), .m_trans(T_ID),
      .m_rdata(ovl_rdata), .m_ready(ovl_ready), .m_resp(ovl_resp), .s_sel(ovl_sel),
      .s_rdata(s_rdata), .s_ready(4'hF), .s_resp(4'h0), .timeout(ovl_tmo)
   );

   typedef struct packed {
      logic [3:0]  sel;
      logic        rdy;
      logic        resp;
      logic        dchk;
      logic [31:0] rdata;
      logic        tmo;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   logic  exp_tmo = 1'b0;
   int    n_chk  = 0;
   int    n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of master/slave inputs and queue what the bus must show in that cycle.
   task automatic step(input string tag, input logic [31:0] addr, input logic [1:0] trans,
                       input logic [3:0] rdy, input logic [3:0] resp, input logic [3:0] esel,
                       input logic erdy, input logic eresp, input logic dchk, input logic [31:0] edat);
      exp_t e;
      @(posedge clk);
      #1;
      m_addr  = addr;
      m_trans = trans;
      s_ready = rdy;
      s_resp  = resp;
      e.sel   = esel;
      e.rdy   = erdy;
      e.resp  = eresp;
      e.dchk  = dchk;
      e.rdata = edat;
      e.tmo   = exp_tmo;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   always @(negedge clk) begin
      exp_t  e;
      string t;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         chk({t, ".sel"},  32'(s_sel),   32'(e.sel));
         chk({t, ".rdy"},  32'(m_ready), 32'(e.rdy));
         chk({t, ".resp"}, 32'(m_resp),  32'(e.resp));
         chk({t, ".tmo"},  32'(timeout), 32'(e.tmo));
         if (e.dchk) chk({t, ".rdata"}, m_rdata, e.rdata);
      end
   end

   initial begin
      step("reset",   32'h0000, T_ID, 4'hF, 4'h0, 4'b0001, 1, 0, 1, 32'h0);
      #6 rst = 1'b0;

      step("t1_addr", 32'h1004, T_NS, 4'hF, 4'h0, 4'b0010, 1, 0, 1, 32'h0);
      step("t1_data", 32'h0000, T_ID, 4'hF, 4'h0, 4'b0001, 1, 0, 1, 32'hCAFE);

      step("t2_addr", 32'h9000, T_NS, 4'hF, 4'h0, 4'b0000, 1, 0, 1, 32'h0);
      step("t2_err1", 32'h9000, T_ID, 4'hF, 4'h0, 4'b0000, 0, 1, 0, 32'h0);
      step("t2_err2", 32'h9000, T_ID, 4'hF, 4'h0, 4'b0000, 1, 1, 0, 32'h0);
      step("t2_done", 32'h9000, T_ID, 4'hF, 4'h0, 4'b0000, 1, 0, 1, 32'h0);

      step("t3_a0",   32'h0000, T_NS, 4'hF, 4'h0, 4'b0001, 1, 0, 1, 32'h0);
      step("t3_w1",   32'h2000, T_SQ, 4'hE, 4'h0, 4'b0100, 0, 0, 1, 32'hA0A0);
      step("t3_w2",   32'h3000, T_NS, 4'hE, 4'h0, 4'b1000, 0, 0, 1, 32'hA0A0);
      step("t3_w3",   32'h2000, T_SQ, 4'hE, 4'h0, 4'b0100, 0, 0, 1, 32'hA0A0);
      step("t3_d0",   32'h2000, T_SQ, 4'hF, 4'h0, 4'b0100, 1, 0, 1, 32'hA0A0);
      step("t3_d2",   32'h0000, T_ID, 4'hF, 4'h0, 4'b0001, 1, 0, 1, 32'hB2B2);

      step("t4_a3",   32'h3000, T_NS, 4'hF, 4'h0, 4'b1000, 1, 0, 1, 32'h0);
      step("t4_e1",   32'h0000, T_ID, 4'h7, 4'h8, 4'b0001, 0, 1, 1, 32'hD3D3);
      step("t4_e2",   32'h0000, T_ID, 4'hF, 4'h8, 4'b0001, 1, 1, 1, 32'hD3D3);
      step("t4_done", 32'h0000, T_ID, 4'hF, 4'h0, 4'b0001, 1, 0, 1, 32'h0);

      step("t5_idle", 32'h9000, T_ID, 4'hF, 4'h0, 4'b0000, 1, 0, 1, 32'h0);
      step("t5_busy", 32'h9000, T_BS, 4'hF, 4'h0, 4'b0000, 1, 0, 1, 32'h0);
      step("t5_done", 32'h0004, T_ID, 4'hF, 4'h0, 4'b0001, 1, 0, 1, 32'h0);
      @(negedge clk);
      #1 chk("ovl_sel", 32'(ovl_sel), 32'h1);

      step("t6_addr", 32'h9000, T_NS, 4'hF, 4'h0, 4'b0000, 1, 0, 1, 32'h0);
      step("t6_err1", 32'h9000, T_ID, 4'hF, 4'h0, 4'b0000, 0, 1, 0, 32'h0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_rdy",   32'(m_ready), 32'h1);
      chk("rst_resp",  32'(m_resp),  32'h0);
      chk("rst_rdata", m_rdata,      32'h0);
      #1 rst = 1'b0;
      step("t6_a3",   32'h3000, T_NS, 4'hF, 4'h0, 4'b1000, 1, 0, 1, 32'h0);
      step("t6_d3",   32'h0000, T_ID, 4'hF, 4'h0, 4'b0001, 1, 0, 1, 32'hD3D3);

`ifdef AHB_ROUTER_TIMEOUT_EN
      step("to_addr", 32'h1000, T_NS, 4'hF, 4'h0, 4'b0010, 1, 0, 1, 32'h0);
      for (int i = 0; i < 8; i++)
         step("to_wait", 32'h0000, T_ID, 4'hD, 4'h0, 4'b0001, 0, 0, 1, 32'hCAFE);
      exp_tmo = 1'b1;
      step("to_err1", 32'h0000, T_ID, 4'hF, 4'h0, 4'b0001, 0, 1, 0, 32'h0);
      step("to_err2", 32'h0000, T_ID, 4'hF, 4'h0, 4'b0001, 1, 1, 0, 32'h0);
      step("to_done", 32'h0000, T_ID, 4'hF, 4'h0, 4'b0001, 1, 0, 1, 32'h0);
      step("to_stky", 32'h1000, T_ID, 4'hF, 4'h0, 4'b0010, 1, 0, 1, 32'h0);
`endif

      step("final",   32'h9000, T_ID, 4'hF, 4'h0, 4'b0000, 1, 0, 1, 32'h0);
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
